// File: rtl/dm_banked_rw_if.sv
// Request/response bus between the EX/MEM stage and the data memory.
//
// Signals (i_ = into the memory, o_ = out of the memory):
//   i_req    access request, sampled by the memory only while idle
//   i_we     1 = store, 0 = load
//   i_size   00 byte, 01 half, 10 word, 11 illegal
//   i_unsign loads only: 1 zero-extend, 0 sign-extend
//   i_addr   byte address
//   i_wdata  store data (low bytes used for byte/half stores)
//   o_busy   memory is not idle
//   o_done   one-cycle completion pulse
//   o_fault  valid with o_done, 1 = access rejected
//   o_rdata  load result, valid with o_done and held until the next o_done
//
// Modports: master = requester (CPU datapath), slave = the memory.
interface dm_banked_rw_if #(
    parameter int ADDR_W = 9
);
    logic              i_req;
    logic              i_we;
    logic [1:0]        i_size;
    logic              i_unsign;
    logic [ADDR_W-1:0] i_addr;
    logic [31:0]       i_wdata;
    logic              o_busy;
    logic              o_done;
    logic              o_fault;
    logic [31:0]       o_rdata;

    modport master (
        output i_req, i_we, i_size, i_unsign, i_addr, i_wdata,
        input  o_busy, o_done, o_fault, o_rdata
    );

    modport slave (
        input  i_req, i_we, i_size, i_unsign, i_addr, i_wdata,
        output o_busy, o_done, o_fault, o_rdata
    );
endinterface

// File: rtl/dm_banked_rw.sv
// Byte-addressed, little-endian data memory with a request/done handshake,
// a programmable number of wait states and registered read data. Supports
// lb/lbu/lh/lhu/lw/sb/sh/sw and rejects misaligned or out-of-range accesses.
//
// Ports:
//   clk  clock, all state changes on the rising edge
//   rst  asynchronous active-high reset
//   bus  dm_banked_rw_if slave modport (request in, busy/done/fault/rdata out)
//
// Parameters:
//   DEPTH  memory size in bytes (power of two, >= 4)
//   ADDR_W address width, 2**ADDR_W == DEPTH
//   LAT    wait-state cycles per access (0..15)
module dm_banked_rw #(
    parameter int DEPTH  = 512,
    parameter int ADDR_W = 9,
    parameter int LAT    = 1
) (
    input  logic           clk,
    input  logic           rst,
    dm_banked_rw_if.slave  bus
);

    localparam int AW1 = ADDR_W + 1;
    localparam logic [ADDR_W:0] DEPTH_L = AW1'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t            r_state;
    logic [3:0]        r_cnt;
    logic              r_we;
    logic [1:0]        r_size;
    logic              r_unsign;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic              r_busy;
    logic              r_done;
    logic              r_fault;
    logic [31:0]       r_rdata;

    logic [7:0]        r_mem [DEPTH];

    logic [2:0]        w_bytes;
    logic [ADDR_W:0]   w_end;
    logic              w_fault;
    logic              w_doAccess;
    logic [7:0]        w_b0;
    logic [7:0]        w_b1;
    logic [7:0]        w_b2;
    logic [7:0]        w_b3;
    logic [31:0]       w_load;

    // Fault check on the latched request. The end address is computed one bit
    // wider than the address so that an access running past the top of memory
    // is caught instead of wrapping back to address 0.
    always_comb begin
        w_bytes = 3'd0;
        case (r_size)
            2'b00:   w_bytes = 3'd1;
            2'b01:   w_bytes = 3'd2;
            2'b10:   w_bytes = 3'd4;
            default: w_bytes = 3'd0;
        endcase
        w_end   = {1'b0, r_addr} + AW1'(w_bytes);
        w_fault = (r_size == 2'b11)
                | ((r_size == 2'b01) && r_addr[0])
                | ((r_size == 2'b10) && (r_addr[1:0] != 2'b00))
                | (w_end > DEPTH_L);
    end

    // The access happens on the edge where the wait counter has run out.
    assign w_doAccess = (r_state == WAIT) && (r_cnt == 4'd0);

    // Read the four bytes starting at the latched address. The index arithmetic
    // wraps within ADDR_W bits, so it always stays inside the array; wrapped
    // bytes are only ever seen on a faulted access, whose result is discarded.
    assign w_b0 = r_mem[r_addr];
    assign w_b1 = r_mem[r_addr + ADDR_W'(1)];
    assign w_b2 = r_mem[r_addr + ADDR_W'(2)];
    assign w_b3 = r_mem[r_addr + ADDR_W'(3)];

    // Assemble the little-endian load result with sign or zero extension.
    // Words ignore the unsign flag.
    always_comb begin
        w_load = {w_b3, w_b2, w_b1, w_b0};
        case (r_size)
            2'b00: w_load = r_unsign ? {24'd0, w_b0} : {{24{w_b0[7]}}, w_b0};
            2'b01: w_load = r_unsign ? {16'd0, w_b1, w_b0}
                                     : {{16{w_b1[7]}}, w_b1, w_b0};
            default: w_load = {w_b3, w_b2, w_b1, w_b0};
        endcase
    end

    // Storage array. It has no reset on purpose: contents survive rst. An
    // aborted store never lands because reset forces the state out of WAIT
    // asynchronously, so w_doAccess is low on every edge after reset asserts.
    always_ff @(posedge clk) begin
        if (w_doAccess && r_we && !w_fault) begin
            case (r_size)
                2'b00: begin
                    r_mem[r_addr] <= r_wdata[7:0];
                end
                2'b01: begin
                    r_mem[r_addr]              <= r_wdata[7:0];
                    r_mem[r_addr + ADDR_W'(1)] <= r_wdata[15:8];
                end
                default: begin
                    r_mem[r_addr]              <= r_wdata[7:0];
                    r_mem[r_addr + ADDR_W'(1)] <= r_wdata[15:8];
                    r_mem[r_addr + ADDR_W'(2)] <= r_wdata[23:16];
                    r_mem[r_addr + ADDR_W'(3)] <= r_wdata[31:24];
                end
            endcase
        end
    end

    // Handshake FSM with registered outputs. IDLE latches a request and loads
    // the wait counter; WAIT counts down and performs the access when the
    // counter is zero; RESP holds done for one cycle and returns to IDLE.
    // Requests arriving outside IDLE are simply not looked at.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= 4'd0;
            r_we     <= 1'b0;
            r_size   <= 2'b00;
            r_unsign <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= 32'd0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_fault  <= 1'b0;
            r_rdata  <= 32'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.i_req) begin
                        r_we     <= bus.i_we;
                        r_size   <= bus.i_size;
                        r_unsign <= bus.i_unsign;
                        r_addr   <= bus.i_addr;
                        r_wdata  <= bus.i_wdata;
                        r_cnt    <= 4'(LAT);
                        r_busy   <= 1'b1;
                        r_state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_done  <= 1'b1;
                        r_fault <= w_fault;
                        if (w_fault) begin
                            r_rdata <= 32'd0;
                        end else if (!r_we) begin
                            r_rdata <= w_load;
                        end
                        r_state <= RESP;
                    end
                end
                RESP: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.o_busy  = r_busy;
    assign bus.o_done  = r_done;
    assign bus.o_fault = r_fault;
    assign bus.o_rdata = r_rdata;

endmodule

// File: tb/tb_dm_banked_rw.sv
// Self-checking bench for dm_banked_rw. A LAT=1 instance carries the
// functional sequence (stores, loads, extension, faults, reset abort, ignored
// requests); a LAT=0 instance is used for the back-to-back throughput check.
// Expected results are queued when a request is driven and compared when done
// pulses.
module tb_dm_banked_rw;

    localparam int LAT1 = 1;

    typedef struct packed {
        logic        fault;
        logic [31:0] rdata;
    } exp_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    logic [31:0] lastRd;
    exp_t sbQ[$];

    dm_banked_rw_if #(.ADDR_W(9)) bus1 ();
    dm_banked_rw_if #(.ADDR_W(9)) bus0 ();

    dm_banked_rw #(.DEPTH(512), .ADDR_W(9), .LAT(LAT1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    dm_banked_rw #(.DEPTH(512), .ADDR_W(9), .LAT(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: counts it, and on mismatch counts a failure and reports.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Pops the oldest expectation and compares it with the DUT outputs.
    task automatic checkOutput(input string tag);
        exp_t e;
        check({tag, "/pending"}, 32'(sbQ.size()), 32'd1);
        if (sbQ.size() > 0) begin
            e = sbQ.pop_front();
            check({tag, "/fault"}, {31'd0, bus1.o_fault}, {31'd0, e.fault});
            check({tag, "/rdata"}, bus1.o_rdata, e.rdata);
        end
    endtask

    // Drives one request on the LAT=1 instance (called at a negedge), checks
    // busy after acceptance, the done latency, the result, the single-cycle
    // done pulse and the return to idle.
    task automatic applyStimulus(input string tag, input logic we, input logic [1:0] size,
                                 input logic uns, input logic [8:0] addr,
                                 input logic [31:0] wdata, input logic expFault,
                                 input logic [31:0] expRd);
        exp_t e;
        int   k;
        e.fault = expFault;
        e.rdata = (we && !expFault) ? lastRd : expRd;
        lastRd  = e.rdata;
        sbQ.push_back(e);
        bus1.i_req    = 1'b1;
        bus1.i_we     = we;
        bus1.i_size   = size;
        bus1.i_unsign = uns;
        bus1.i_addr   = addr;
        bus1.i_wdata  = wdata;
        @(negedge clk);
        bus1.i_req = 1'b0;
        check({tag, "/busy"}, {31'd0, bus1.o_busy}, 32'd1);
        k = 0;
        while (bus1.o_done !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check({tag, "/latency"}, 32'(k), 32'(LAT1 + 1));
        if (bus1.o_done === 1'b1) begin
            checkOutput(tag);
        end else if (sbQ.size() > 0) begin
            void'(sbQ.pop_front());
        end
        @(negedge clk);
        check({tag, "/donepulse"}, {31'd0, bus1.o_done}, 32'd0);
        check({tag, "/idle"}, {31'd0, bus1.o_busy}, 32'd0);
    endtask

    initial begin
        int doneCnt;
        int lastI;
        exp_t e;
        total  = 0;
        bad    = 0;
        lastRd = 32'd0;
        rst    = 1'b1;
        bus1.i_req = 1'b0; bus1.i_we = 1'b0; bus1.i_size = 2'b00;
        bus1.i_unsign = 1'b0; bus1.i_addr = '0; bus1.i_wdata = 32'd0;
        bus0.i_req = 1'b0; bus0.i_we = 1'b0; bus0.i_size = 2'b00;
        bus0.i_unsign = 1'b0; bus0.i_addr = '0; bus0.i_wdata = 32'd0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst/busy",  {31'd0, bus1.o_busy},  32'd0);
        check("rst/done",  {31'd0, bus1.o_done},  32'd0);
        check("rst/fault", {31'd0, bus1.o_fault}, 32'd0);
        check("rst/rdata", bus1.o_rdata,          32'd0);
        rst = 1'b0;

        // Word store then load, extension variants.
        applyStimulus("sw10",   1'b1, 2'b10, 1'b0, 9'h010, 32'h8899AABB, 1'b0, 32'd0);
        applyStimulus("lw10",   1'b0, 2'b10, 1'b0, 9'h010, 32'd0, 1'b0, 32'h8899AABB);
        applyStimulus("lb10",   1'b0, 2'b00, 1'b0, 9'h010, 32'd0, 1'b0, 32'hFFFFFFBB);
        applyStimulus("lbu10",  1'b0, 2'b00, 1'b1, 9'h010, 32'd0, 1'b0, 32'h000000BB);
        applyStimulus("lh12",   1'b0, 2'b01, 1'b0, 9'h012, 32'd0, 1'b0, 32'hFFFF8899);
        applyStimulus("lhu12",  1'b0, 2'b01, 1'b1, 9'h012, 32'd0, 1'b0, 32'h00008899);
        applyStimulus("lb11",   1'b0, 2'b00, 1'b0, 9'h011, 32'd0, 1'b0, 32'hFFFFFFAA);

        // Partial stores merge into the word.
        applyStimulus("sb11",   1'b1, 2'b00, 1'b0, 9'h011, 32'h00000055, 1'b0, 32'd0);
        applyStimulus("sh12",   1'b1, 2'b01, 1'b0, 9'h012, 32'h00001234, 1'b0, 32'd0);
        applyStimulus("lw10b",  1'b0, 2'b10, 1'b0, 9'h010, 32'd0, 1'b0, 32'h123455BB);

        // Faults and boundaries.
        applyStimulus("lw13",   1'b0, 2'b10, 1'b0, 9'h013, 32'd0, 1'b1, 32'd0);
        applyStimulus("sw20",   1'b1, 2'b10, 1'b0, 9'h020, 32'hCAFEF00D, 1'b0, 32'd0);
        applyStimulus("sh21",   1'b1, 2'b01, 1'b0, 9'h021, 32'h0000FFFF, 1'b1, 32'd0);
        applyStimulus("lw20",   1'b0, 2'b10, 1'b0, 9'h020, 32'd0, 1'b0, 32'hCAFEF00D);
        applyStimulus("size11", 1'b0, 2'b11, 1'b0, 9'h030, 32'd0, 1'b1, 32'd0);
        applyStimulus("sw1fc",  1'b1, 2'b10, 1'b0, 9'h1FC, 32'h01020304, 1'b0, 32'd0);
        applyStimulus("lw1fc",  1'b0, 2'b10, 1'b0, 9'h1FC, 32'd0, 1'b0, 32'h01020304);
        applyStimulus("lh1ff",  1'b0, 2'b01, 1'b0, 9'h1FF, 32'd0, 1'b1, 32'd0);
        applyStimulus("lb1ff",  1'b0, 2'b00, 1'b0, 9'h1FF, 32'd0, 1'b0, 32'h00000001);
        applyStimulus("lhu1fe", 1'b0, 2'b01, 1'b1, 9'h1FE, 32'd0, 1'b0, 32'h00000102);

        // Request held high through WAIT/RESP: only the first is served, and
        // the address change after acceptance must not leak in.
        e.fault = 1'b0;
        e.rdata = 32'h123455BB;
        sbQ.push_back(e);
        bus1.i_req = 1'b1; bus1.i_we = 1'b0; bus1.i_size = 2'b10;
        bus1.i_unsign = 1'b0; bus1.i_addr = 9'h010;
        doneCnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 0) bus1.i_addr = 9'h020;
            if (i == 3) bus1.i_req = 1'b0;
            if (bus1.o_done === 1'b1) begin
                doneCnt++;
                checkOutput("holdreq");
            end
        end
        check("holdreq/count", 32'(doneCnt), 32'd1);
        lastRd = 32'h123455BB;

        // Reset during WAIT aborts a store.
        applyStimulus("sw40",   1'b1, 2'b10, 1'b0, 9'h040, 32'h11223344, 1'b0, 32'd0);
        bus1.i_req = 1'b1; bus1.i_we = 1'b1; bus1.i_size = 2'b10;
        bus1.i_addr = 9'h040; bus1.i_wdata = 32'hDEADBEEF;
        @(negedge clk);
        bus1.i_req = 1'b0;
        check("abort/busybefore", {31'd0, bus1.o_busy}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("abort/busy",  {31'd0, bus1.o_busy},  32'd0);
        check("abort/done",  {31'd0, bus1.o_done},  32'd0);
        check("abort/fault", {31'd0, bus1.o_fault}, 32'd0);
        check("abort/rdata", bus1.o_rdata,          32'd0);
        @(negedge clk);
        rst = 1'b0;
        lastRd = 32'd0;
        doneCnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus1.o_done === 1'b1) doneCnt++;
        end
        check("abort/nodone", 32'(doneCnt), 32'd0);
        applyStimulus("lw40",   1'b0, 2'b10, 1'b0, 9'h040, 32'd0, 1'b0, 32'h11223344);

        // LAT=0 with req held high: one done every 3 cycles.
        bus0.i_req = 1'b1; bus0.i_we = 1'b1; bus0.i_size = 2'b10;
        bus0.i_addr = 9'h000; bus0.i_wdata = 32'h00000005;
        doneCnt = 0;
        lastI   = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus0.o_done === 1'b1) begin
                if (doneCnt > 0) check("lat0/gap", 32'(i - lastI), 32'd3);
                check("lat0/fault", {31'd0, bus0.o_fault}, 32'd0);
                doneCnt++;
                lastI = i;
            end
        end
        bus0.i_req = 1'b0;
        check("lat0/count", 32'(doneCnt), 32'd10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dm_banked_rw.md
Name: dm_banked_rw

Overview:
- Parametrised, byte-addressed, little-endian data memory for the single-cycle and multi-cycle CPU datapaths.
- Supports byte, half and word loads and stores (lb/lbu/lh/lhu/lw/sb/sh/sw).
- Uses a request/done handshake with a programmable number of wait states, registered read data, and detection of misaligned or out-of-range accesses.
- Sits between the EX/MEM stage and the writeback mux. It is the next-generation replacement for the combinational-read data memory.

Parameters:
- DEPTH, 512, memory size in bytes; must be a power of two and at least 4.
- ADDR_W, 9, address width in bits; must satisfy 2**ADDR_W == DEPTH.
- LAT, 1, number of wait-state cycles per access; legal range 0..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  1  access request; sampled only in IDLE.
- we  in  1  1 = store, 0 = load; sampled with req.
- size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- unsign  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- addr  in  ADDR_W  byte address.
- wdata  in  32  store data; the low bytes are used for byte and half stores.
- busy  out  1  high when the state is not IDLE.
- done  out  1  one-cycle completion pulse.
- fault  out  1  valid with done; 1 = access rejected.
- rdata  out  32  load result; valid with done and held until the next done.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- On rst:
  - state is set to IDLE.
  - busy = 0, done = 0, fault = 0, rdata = 0, wait counter = 0.
  - Any pending store is discarded.
  - Memory contents are not reset.
- States are IDLE, WAIT and RESP.
- IDLE:
  - If req = 1 at edge N, latch we, size, unsign, addr and wdata, load cnt = LAT, and go to WAIT.
  - If req = 0, stay in IDLE.
  - req in any other state is ignored and not queued.
- WAIT:
  - At each edge, if cnt != 0, decrement cnt.
  - If cnt == 0, perform the access and go to RESP.
  - The access therefore executes at edge N+LAT+1.
- RESP:
  - done = 1 for exactly one cycle, then return to IDLE.
  - Back-to-back throughput is one access per LAT+3 cycles.
  - A req sampled in the IDLE cycle immediately after RESP is accepted.
- Fault check is performed on the latched request. fault = 1 when any of these hold:
  - size == 11.
  - size == 01 and addr[0] != 0.
  - size == 10 and addr[1:0] != 0.
  - addr + access_bytes > DEPTH (no wrap-around).
- On fault: no memory byte is written, rdata is set to 0, and done still pulses.
- Stores are little-endian:
  - sb writes mem[a] = wdata[7:0].
  - sh writes mem[a] = wdata[7:0] and mem[a+1] = wdata[15:8].
  - sw writes bytes a..a+3 from wdata[7:0] through wdata[31:24].
  - All bytes of one store commit on the same edge. rdata is unchanged on a store.
- Loads are little-endian:
  - lw returns {m[a+3], m[a+2], m[a+1], m[a]}.
  - lh/lhu return {ext16, m[a+1], m[a]}, where ext is m[a+1][7] for lh and 0 for lhu.
  - lb/lbu return {ext24, m[a]}, where ext is m[a][7] for lb and 0 for lbu.
  - unsign is ignored for words.
- Memory is read at the access edge and registered into rdata, so the value is stable throughout the done cycle.
- A load following a store to the same address returns the stored data, because the store has committed before the next access is accepted.
- Reset mid-operation (asserted in WAIT or RESP): the state returns to IDLE immediately, no write occurs, and done is never pulsed for the aborted request.
- No outputs are ever high-impedance.

Test Plan:
- Latency, LAT=1: sw addr=0x10, wdata=0x8899AABB accepted at edge 0 -> busy high from edge 0, done=1 and fault=0 for one cycle after edge 2; then lw addr=0x10 -> rdata=0x8899AABB with done.
- Sign and zero extension: after the store above, load addr=0x10:
  - lb -> 0xFFFFFFBB.
  - lbu -> 0x000000BB.
  - lh addr=0x12 -> 0xFFFF8899.
  - lhu addr=0x12 -> 0x00008899.
  - lb addr=0x11 -> 0xFFFFFFAA.
- Partial stores: sb addr=0x11 wdata=0x00000055, then sh addr=0x12 wdata=0x00001234 -> lw addr=0x10 returns 0x123455BB.
- Faults:
  - lw addr=0x13 -> done with fault=1, rdata=0.
  - sh addr=0x21 -> fault=1, and word 0x20 is unchanged.
  - size=11 -> fault=1.
  - sw addr=0x1FC -> fault=0.
  - lh addr=0x1FF -> fault=1.
- Handshake: hold req=1 continuously with LAT=0 -> exactly one done per 3 cycles; req pulsed during WAIT -> ignored, exactly one done.
- Reset: assert rst in WAIT during sw addr=0x40 wdata=0xDEADBEEF -> busy, done, fault and rdata go to 0 immediately; the subsequent lw addr=0x40 returns the prior contents of that word.
